norm_issue_arbiter: RTL and testbench

Round-robin arbiter and pipeline controller that shares one combinational `normalization` unit between `NUM_REQ` MAC lanes in the SD4_MAC datapath. Each lane offers a 20-bit signed sum and a 6-bit maximum exponent over a valid/ready handshake. The block registers the winning operand and drives it into the shared normalizer. It captures the normalizer result with the lane tag and presents it downstream with backpressure, sustaining one operation per cycle.

---
 rtl/norm_issue_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_norm_issue_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_issue_arbiter.sv
// norm_issue_arbiter
//   Round-robin arbiter and two-stage pipeline controller that shares one
//   combinational normalization unit between NUM_REQ MAC lanes.
//
//   Ports
//     clk, rst                    : clock, asynchronous active-high reset
//     req_valid/req_ready         : per-lane handshake (req_ready one-hot)
//     req_sum  [NUM_REQ*20-1:0]   : lane i sum at [20i+19:20i], signed
//     req_exp  [NUM_REQ*6-1:0]    : lane i max exponent at [6i+5:6i]
//     nu_signed_sum, nu_exp_max   : operand register driven into normalizer
//     nu_sign, nu_norm_sum,
//     nu_exp_final                : normalizer result (combinational)
//     out_valid/out_ready         : result handshake toward downstream
//     out_tag, out_sign,
//     out_norm_sum, out_exp_final,
//     out_zero, out_exp_ovf       : registered result fields
//     done_cnt                    : results accepted downstream (wrapping)
module norm_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*20-1:0]  req_sum,
  input  logic [NUM_REQ*6-1:0]   req_exp,
  output logic [19:0]            nu_signed_sum,
  output logic [5:0]             nu_exp_max,
  input  logic                   nu_sign,
  input  logic [10:0]            nu_norm_sum,
  input  logic [6:0]             nu_exp_final,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_sign,
  output logic [10:0]            out_norm_sum,
  output logic [6:0]             out_exp_final,
  output logic                   out_zero,
  output logic                   out_exp_ovf,
  output logic [15:0]            done_cnt
);

  // Operand stage
  logic              op_v_q,   op_v_d;
  logic [TAG_W-1:0]  op_tag_q, op_tag_d;
  logic [19:0]       op_sum_q, op_sum_d;
  logic [5:0]        op_exp_q, op_exp_d;
  logic [TAG_W-1:0]  last_q,   last_d;

  // Result stage
  logic              out_valid_q,     out_valid_d;
  logic [TAG_W-1:0]  out_tag_q,       out_tag_d;
  logic              out_sign_q,      out_sign_d;
  logic [10:0]       out_norm_sum_q,  out_norm_sum_d;
  logic [6:0]        out_exp_final_q, out_exp_final_d;
  logic              out_zero_q,      out_zero_d;
  logic              out_exp_ovf_q,   out_exp_ovf_d;
  logic [15:0]       done_cnt_q,      done_cnt_d;

  logic              res_free, op_adv, op_free, xfer;
  logic              grant_found;
  logic [TAG_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  cand;
  logic [19:0]       sel_sum;
  logic [5:0]        sel_exp;

  assign res_free = !out_valid_q || out_ready;
  assign op_adv   = op_v_q && res_free;
  assign op_free  = !op_v_q || op_adv;

  // Rotating search starting just after the last winner; first hit wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = TAG_W'((32'(last_q) + off) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Grant is suppressed while reset is asserted so req_ready reads 0
  // immediately, not only after the registers clear.
  always_comb begin
    req_ready = '0;
    if (grant_found && op_free && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer = |req_ready;

  always_comb begin
    sel_sum = '0;
    sel_exp = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) begin
        sel_sum = req_sum[20*i +: 20];
        sel_exp = req_exp[6*i +: 6];
      end
    end
  end

  always_comb begin
    op_v_d   = op_v_q;
    op_tag_d = op_tag_q;
    op_sum_d = op_sum_q;
    op_exp_d = op_exp_q;
    last_d   = last_q;
    if (xfer) begin
      op_v_d   = 1'b1;
      op_tag_d = grant_idx;
      op_sum_d = sel_sum;
      op_exp_d = sel_exp;
      last_d   = grant_idx;
    end else if (op_adv) begin
      op_v_d   = 1'b0;
    end
  end

  always_comb begin
    out_valid_d     = out_valid_q;
    out_tag_d       = out_tag_q;
    out_sign_d      = out_sign_q;
    out_norm_sum_d  = out_norm_sum_q;
    out_exp_final_d = out_exp_final_q;
    out_zero_d      = out_zero_q;
    out_exp_ovf_d   = out_exp_ovf_q;
    if (op_adv) begin
      out_valid_d     = 1'b1;
      out_tag_d       = op_tag_q;
      out_sign_d      = nu_sign;
      out_norm_sum_d  = nu_norm_sum;
      out_exp_final_d = nu_exp_final;
      out_zero_d      = (op_sum_q == '0);
      out_exp_ovf_d   = nu_exp_final[6];
    end else if (out_ready) begin
      out_valid_d     = 1'b0;
    end
    done_cnt_d = done_cnt_q + {15'd0, (out_valid_q && out_ready)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_v_q          <= 1'b0;
      op_tag_q        <= '0;
      op_sum_q        <= '0;
      op_exp_q        <= '0;
      last_q          <= TAG_W'(NUM_REQ - 1);
      out_valid_q     <= 1'b0;
      out_tag_q       <= '0;
      out_sign_q      <= 1'b0;
      out_norm_sum_q  <= '0;
      out_exp_final_q <= '0;
      out_zero_q      <= 1'b0;
      out_exp_ovf_q   <= 1'b0;
      done_cnt_q      <= '0;
    end else begin
      op_v_q          <= op_v_d;
      op_tag_q        <= op_tag_d;
      op_sum_q        <= op_sum_d;
      op_exp_q        <= op_exp_d;
      last_q          <= last_d;
      out_valid_q     <= out_valid_d;
      out_tag_q       <= out_tag_d;
      out_sign_q      <= out_sign_d;
      out_norm_sum_q  <= out_norm_sum_d;
      out_exp_final_q <= out_exp_final_d;
      out_zero_q      <= out_zero_d;
      out_exp_ovf_q   <= out_exp_ovf_d;
      done_cnt_q      <= done_cnt_d;
    end
  end

  assign nu_signed_sum = op_sum_q;
  assign nu_exp_max    = op_exp_q;
  assign out_valid     = out_valid_q;
  assign out_tag       = out_tag_q;
  assign out_sign      = out_sign_q;
  assign out_norm_sum  = out_norm_sum_q;
  assign out_exp_final = out_exp_final_q;
  assign out_zero      = out_zero_q;
  assign out_exp_ovf   = out_exp_ovf_q;
  assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_norm_issue_arbiter.sv
// Directed bench for norm_issue_arbiter with a simple behavioural normalizer:
//   sign = sum[19], norm_sum = |sum| >> 9, exp_final = exp + 4.
module tb_norm_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [79:0] req_sum;
  logic [23:0] req_exp;
  logic [19:0] nu_signed_sum;
  logic [5:0]  nu_exp_max;
  logic        nu_sign;
  logic [10:0] nu_norm_sum;
  logic [6:0]  nu_exp_final;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_tag;
  logic        out_sign;
  logic [10:0] out_norm_sum;
  logic [6:0]  out_exp_final;
  logic        out_zero;
  logic        out_exp_ovf;
  logic [15:0] done_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  norm_issue_arbiter #(.NUM_REQ(4), .TAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sum(req_sum), .req_exp(req_exp),
    .nu_signed_sum(nu_signed_sum), .nu_exp_max(nu_exp_max),
    .nu_sign(nu_sign), .nu_norm_sum(nu_norm_sum), .nu_exp_final(nu_exp_final),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_sign(out_sign), .out_norm_sum(out_norm_sum),
    .out_exp_final(out_exp_final), .out_zero(out_zero),
    .out_exp_ovf(out_exp_ovf), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  logic [19:0] mag;
  always_comb begin
    mag          = nu_signed_sum[19] ? (20'd0 - nu_signed_sum) : nu_signed_sum;
    nu_sign      = nu_signed_sum[19];
    nu_norm_sum  = mag[19:9];
    nu_exp_final = {1'b0, nu_exp_max} + 7'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Next cycle: registered outputs reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_lane(input int lane, input logic [19:0] s, input logic [5:0] e);
    req_sum[20*lane +: 20] = s;
    req_exp[6*lane +: 6]   = e;
  endtask

  // One isolated transfer on an otherwise idle block, out_ready high.
  task automatic run_one(input int lane, input logic [19:0] s, input logic [5:0] e,
                         input logic x_sign, input logic [10:0] x_norm,
                         input logic [6:0] x_ef, input logic x_zero, input logic x_ovf);
    set_lane(lane, s, e);
    req_valid = 4'(1 << lane);
    out_ready = 1'b1;
    #1;
    chk("one_grant", 32'(req_ready), 32'(1 << lane));
    step();
    req_valid = '0;
    #1;
    chk("one_nu_sum", 32'(nu_signed_sum), 32'(s));
    chk("one_nu_exp", 32'(nu_exp_max), 32'(e));
    chk("one_valid_k1", 32'(out_valid), 32'd0);
    step();
    chk("one_valid_k2", 32'(out_valid), 32'd1);
    chk("one_tag", 32'(out_tag), 32'(lane));
    chk("one_sign", 32'(out_sign), 32'(x_sign));
    chk("one_norm", 32'(out_norm_sum), 32'(x_norm));
    chk("one_ef", 32'(out_exp_final), 32'(x_ef));
    chk("one_zero", 32'(out_zero), 32'(x_zero));
    chk("one_ovf", 32'(out_exp_ovf), 32'(x_ovf));
    step();
    chk("one_drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_sum = '0;
    req_exp = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    chk("rst_nu_sum", 32'(nu_signed_sum), 32'd0);
    chk("rst_nu_exp", 32'(nu_exp_max), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    chk("rst_ovf", 32'(out_exp_ovf), 32'd0);

    // Single request on lane 1
    do_reset();
    run_one(1, 20'h00400, 6'd10, 1'b0, 11'd2, 7'd14, 1'b0, 1'b0);
    chk("single_done", 32'(done_cnt), 32'd1);

    // All four lanes continuously: grants 0,1,2,3,0,..; results two cycles later
    do_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 20'(20'h01000 * (i + 1)), 6'(i + 1));
    out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) step();
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      chk("rr_grant", 32'(req_ready), (c < 8) ? 32'(1 << (c % 4)) : 32'd0);
      chk("rr_valid", 32'(out_valid), (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 9) begin
        chk("rr_tag", 32'(out_tag), 32'((c - 2) % 4));
        chk("rr_norm", 32'(out_norm_sum), 32'(8 * (((c - 2) % 4) + 1)));
      end
    end
    chk("rr_done", 32'(done_cnt), 32'd8);

    // Backpressure with lanes 0 and 2
    do_reset();
    set_lane(0, 20'h00200, 6'd1);
    set_lane(2, 20'h00600, 6'd3);
    out_ready = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("bp_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0100;
    #1;
    chk("bp_grant2", 32'(req_ready), 32'b0100);
    for (int c = 0; c < 5; c++) begin
      step();
      req_valid = 4'b0101;
      #1;
      chk("bp_stall_ready", 32'(req_ready), 32'd0);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
      chk("bp_stall_tag", 32'(out_tag), 32'd0);
      chk("bp_stall_norm", 32'(out_norm_sum), 32'd1);
      chk("bp_stall_nu", 32'(nu_signed_sum), 32'h00600);
    end
    step();
    out_ready = 1'b1;
    #1;
    chk("bp_rel_tag0", 32'(out_tag), 32'd0);
    chk("bp_rel_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0100;
    #1;
    chk("bp_rel_valid2", 32'(out_valid), 32'd1);
    chk("bp_rel_tag2", 32'(out_tag), 32'd2);
    chk("bp_rel_norm2", 32'(out_norm_sum), 32'd3);
    chk("bp_rel_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    #1;
    chk("bp_tag0b", 32'(out_tag), 32'd0);
    step();
    chk("bp_tag2b", 32'(out_tag), 32'd2);
    chk("bp_valid2b", 32'(out_valid), 32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_done", 32'(done_cnt), 32'd4);

    // Edge values on lane 0
    do_reset();
    run_one(0, 20'h00000, 6'd5,  1'b0, 11'd0,     7'd9,  1'b1, 1'b0);
    run_one(0, 20'h80000, 6'd5,  1'b1, 11'h400,   7'd9,  1'b0, 1'b0);
    run_one(0, 20'h00400, 6'd62, 1'b0, 11'd2,     7'd66, 1'b0, 1'b1);
    chk("edge_done", 32'(done_cnt), 32'd3);

    // Reset while OP and RES are both occupied (last = 0 here)
    set_lane(0, 20'h00200, 6'd1);
    set_lane(2, 20'h00600, 6'd3);
    set_lane(3, 20'h00800, 6'd2);
    out_ready = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("mr_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0001;
    #1;
    chk("mr_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b1001;
    #1;
    chk("mr_full_valid", 32'(out_valid), 32'd1);
    chk("mr_full_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_rst_valid", 32'(out_valid), 32'd0);
    chk("mr_rst_ready", 32'(req_ready), 32'd0);
    chk("mr_rst_done", 32'(done_cnt), 32'd0);
    chk("mr_rst_nu", 32'(nu_signed_sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_first_lane0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b1000;
    #1;
    chk("mr_then_lane3", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;

    // Counter wrap: 65536 back-to-back results from lane 0
    do_reset();
    set_lane(0, 20'h00400, 6'd1);
    out_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("wrap_grant", 32'(req_ready), 32'b0001);
    for (int c = 1; c <= 65537; c++) begin
      step();
      if (c == 65536) req_valid = '0;
    end
    chk("wrap_pre", 32'(done_cnt), 32'd65535);
    chk("wrap_pre_valid", 32'(out_valid), 32'd1);
    step();
    chk("wrap_zero", 32'(done_cnt), 32'd0);
    chk("wrap_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
